// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite channel bundle shared by register-file targets and their masters.
// AW/DW are the address and data widths; strobe width follows DW.
interface axi_lite_channel #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            aw_valid;
  logic            aw_ready;
  logic [AW-1:0]   aw_addr;
  logic [2:0]      aw_prot;
  logic            w_valid;
  logic            w_ready;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            b_valid;
  logic            b_ready;
  logic [1:0]      b_resp;
  logic            ar_valid;
  logic            ar_ready;
  logic [AW-1:0]   ar_addr;
  logic [2:0]      ar_prot;
  logic            r_valid;
  logic            r_ready;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register file: NUM_REGS byte-strobed registers with independent
// single-outstanding write and read paths, DECERR for out-of-range addresses.
module axi_lite_regfile #(
  parameter int unsigned    NUM_REGS    = 16,
  parameter int unsigned    AW          = 32,
  parameter int unsigned    DW          = 32,
  parameter logic [DW-1:0]  RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_channel.slave         master,
  output logic [NUM_REGS*DW-1:0] reg_q,
  output logic [NUM_REGS-1:0]    wr_pulse
);
  localparam int unsigned B  = DW / 8;
  localparam int unsigned BL = $clog2(B);
  localparam int unsigned LN = $clog2(NUM_REGS);
  localparam int unsigned IW = (LN > 0) ? LN : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_RESP } r_state_t;

  w_state_t      w_state;
  r_state_t      r_state;
  logic [DW-1:0] regs [NUM_REGS];

  logic          b_valid_q;
  logic [1:0]    b_resp_q;
  logic          r_valid_q;
  logic [1:0]    r_resp_q;
  logic [DW-1:0] r_data_q;

  logic          aw_hs;
  logic          ar_hs;
  logic [IW-1:0] aw_idx;
  logic [IW-1:0] ar_idx;
  logic          aw_in_range;
  logic          ar_in_range;

  function automatic logic [IW-1:0] reg_index(input logic [AW-1:0] addr);
    logic [AW-1:0] shifted;
    shifted = addr >> BL;
    return (LN > 0) ? shifted[IW-1:0] : '0;
  endfunction

  // In range iff every bit above the register index is zero.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr >> (BL + LN)) == '0;
  endfunction

  assign aw_idx      = reg_index(master.aw_addr);
  assign ar_idx      = reg_index(master.ar_addr);
  assign aw_in_range = in_range(master.aw_addr);
  assign ar_in_range = in_range(master.ar_addr);

  // AW and W are only ever accepted together, so neither channel can run ahead.
  assign aw_hs = !rst && (w_state == W_IDLE) && master.aw_valid && master.w_valid;
  assign ar_hs = !rst && (r_state == R_IDLE) && master.ar_valid;

  assign master.aw_ready = aw_hs;
  assign master.w_ready  = aw_hs;
  assign master.b_valid  = b_valid_q;
  assign master.b_resp   = b_resp_q;
  assign master.ar_ready = !rst && (r_state == R_IDLE);
  assign master.r_valid  = r_valid_q;
  assign master.r_resp   = r_resp_q;
  assign master.r_data   = r_data_q;

  logic unused_prot;
  assign unused_prot = ^{master.aw_prot, master.ar_prot};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[i*DW +: DW] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      wr_pulse  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            if (aw_in_range) begin
              for (int unsigned k = 0; k < B; k++) begin
                if (master.w_strb[k]) begin
                  regs[aw_idx][k*8 +: 8] <= master.w_data[k*8 +: 8];
                end
              end
              wr_pulse[aw_idx] <= 1'b1;
              b_resp_q         <= RESP_OKAY;
            end else begin
              b_resp_q <= RESP_DECERR;
            end
            b_valid_q <= 1'b1;
            w_state   <= W_RESP;
          end
        end
        W_RESP: begin
          if (master.b_ready) begin
            b_valid_q <= 1'b0;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs before this edge's write update lands, so a same-cycle
  // conflict returns the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            if (ar_in_range) begin
              r_data_q <= regs[ar_idx];
              r_resp_q <= RESP_OKAY;
            end else begin
              r_data_q <= '0;
              r_resp_q <= RESP_DECERR;
            end
            r_valid_q <= 1'b1;
            r_state   <= R_RESP;
          end
        end
        R_RESP: begin
          if (master.r_ready) begin
            r_valid_q <= 1'b0;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: table of write/read vectors plus
// hand sequences for reset, channel skew, backpressure, conflicts and mid-flight reset.
module tb_axi_lite_regfile;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  DECERR   = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REGS*DW-1:0] reg_q;
  logic [NUM_REGS-1:0]    wr_pulse;

  axi_lite_channel #(.AW(AW), .DW(DW)) bus ();

  axi_lite_regfile #(
    .NUM_REGS   (NUM_REGS),
    .AW         (AW),
    .DW         (DW),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .master  (bus.slave),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] model [NUM_REGS];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [15:0] pulse;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s reg_q[%0d]", tag, i), reg_q[i*DW +: DW], model[i]);
  endtask

  task automatic idle_bus();
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
    bus.r_ready  = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input logic [15:0] exp_pulse,
                           input string tag);
    int n = 0;
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    bus.aw_addr = a; bus.w_data = d; bus.w_strb = s; bus.b_ready = 1'b0;
    bus.aw_prot = 3'b111;
    #1;
    while (!(bus.aw_ready && bus.w_ready) && n < 16) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 16) check({tag, " aw_handshake_timeout"}, 1'b0, 1'b1);
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.aw_prot = '0;
    check({tag, " b_valid"}, bus.b_valid, 1'b1);
    check({tag, " b_resp"}, bus.b_resp, exp_resp);
    check({tag, " wr_pulse"}, wr_pulse, exp_pulse);
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    check({tag, " b_valid_drop"}, bus.b_valid, 1'b0);
    check({tag, " wr_pulse_drop"}, wr_pulse, 16'h0000);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int n = 0;
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_addr = a; bus.r_ready = 1'b0; bus.ar_prot = 3'b101;
    #1;
    while (!bus.ar_ready && n < 16) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 16) check({tag, " ar_handshake_timeout"}, 1'b0, 1'b1);
    @(negedge clk);
    bus.ar_valid = 1'b0; bus.ar_prot = '0;
    check({tag, " r_valid"}, bus.r_valid, 1'b1);
    check({tag, " r_data"}, bus.r_data, exp_data);
    check({tag, " r_resp"}, bus.r_resp, exp_resp);
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    check({tag, " r_valid_drop"}, bus.r_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, OKAY,   16'h0004};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'h0, OKAY,   16'h0000};
    vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, OKAY,   16'h0002};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h5, OKAY,   16'h0002};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h11BB_33DD, 4'h0, OKAY,   16'h0000};
    vecs[5]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, DECERR, 16'h0000};
    vecs[6]  = '{1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, DECERR, 16'h0000};
    vecs[7]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, OKAY,   16'h8000};
    vecs[8]  = '{1'b0, 32'h0000_003F, 32'hCAFE_F00D, 4'h0, OKAY,   16'h0000};
    vecs[9]  = '{1'b1, 32'h0000_0008, 32'h0000_0000, 4'h0, OKAY,   16'h0004};
    vecs[10] = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'h0, OKAY,   16'h0000};
    vecs[11] = '{1'b1, 32'h0000_0001, 32'h0000_FFFF, 4'h3, OKAY,   16'h0001};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_FFFF, 4'h0, OKAY,   16'h0000};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, DECERR, 16'h0000};
    vecs[14] = '{1'b1, 32'h0000_0400, 32'h7777_7777, 4'hF, DECERR, 16'h0000};
    vecs[15] = '{1'b0, 32'h0000_0010, 32'h5A5A_5A5A, 4'h0, OKAY,   16'h0000};

    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;

    // Reset: outputs quiet and readies low even with every valid asserted.
    idle_bus();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    #1;
    check("rst aw_ready", bus.aw_ready, 1'b0);
    check("rst w_ready", bus.w_ready, 1'b0);
    check("rst ar_ready", bus.ar_ready, 1'b0);
    @(negedge clk);
    check("rst b_valid", bus.b_valid, 1'b0);
    check("rst r_valid", bus.r_valid, 1'b0);
    check("rst wr_pulse", wr_pulse, 16'h0000);
    idle_bus();
    rst = 1'b0;
    @(negedge clk);
    check_regs("rst");
    check("idle ar_ready", bus.ar_ready, 1'b1);
    check("idle aw_ready", bus.aw_ready, 1'b0);

    // Same-cycle read and write to register 1: read sees the old value.
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.aw_addr = 32'h4;
    bus.w_data = 32'h5; bus.w_strb = 4'hF;
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h4;
    #1;
    check("conf aw_ready", bus.aw_ready, 1'b1);
    check("conf ar_ready", bus.ar_ready, 1'b1);
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    model[1] = 32'h5;
    check("conf r_valid", bus.r_valid, 1'b1);
    check("conf r_data_old", bus.r_data, 32'h0);
    check("conf b_valid", bus.b_valid, 1'b1);
    check("conf wr_pulse", wr_pulse, 16'h0002);
    check("conf reg_q[1]", reg_q[1*DW +: DW], 32'h5);
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    check("conf b_done", bus.b_valid, 1'b0);
    check("conf r_done", bus.r_valid, 1'b0);
    axi_read(32'h4, 32'h5, OKAY, "conf reread");

    // AW leads W by three cycles, then the B response is held off for five.
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_addr = 32'h10;
    bus.w_data = 32'h5A5A_5A5A; bus.w_strb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("skew aw_ready c%0d", i), bus.aw_ready, 1'b0);
      check($sformatf("skew w_ready c%0d", i), bus.w_ready, 1'b0);
      @(negedge clk);
      check($sformatf("skew b_valid c%0d", i), bus.b_valid, 1'b0);
      check($sformatf("skew wr_pulse c%0d", i), wr_pulse, 16'h0000);
    end
    check_regs("skew pre");
    bus.w_valid = 1'b1;
    #1;
    check("skew aw_ready", bus.aw_ready, 1'b1);
    check("skew w_ready", bus.w_ready, 1'b1);
    @(negedge clk);
    model[4] = 32'h5A5A_5A5A;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp b_valid c%0d", i), bus.b_valid, 1'b1);
      check($sformatf("bp b_resp c%0d", i), bus.b_resp, OKAY);
      check($sformatf("bp aw_ready c%0d", i), bus.aw_ready, 1'b0);
      check($sformatf("bp w_ready c%0d", i), bus.w_ready, 1'b0);
      @(negedge clk);
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    check("bp b_done", bus.b_valid, 1'b0);
    check_regs("bp");

    // Table-driven vectors.
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, vecs[i].pulse,
                  $sformatf("v%0d", i));
        if (vecs[i].addr < 32'h40)
          for (int k = 0; k < 4; k++)
            if (vecs[i].strb[k]) model[vecs[i].addr[5:2]][k*8 +: 8] = vecs[i].data[k*8 +: 8];
        check_regs($sformatf("v%0d", i));
      end else begin
        axi_read(vecs[i].addr, vecs[i].data, vecs[i].resp, $sformatf("v%0d", i));
      end
    end

    // Reset while both B and R responses are pending.
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.aw_addr = 32'h8;
    bus.w_data = 32'h1212_1212; bus.w_strb = 4'hF;
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h3C;
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    check("mrst b_valid_pre", bus.b_valid, 1'b1);
    check("mrst r_valid_pre", bus.r_valid, 1'b1);
    @(negedge clk);
    check("mrst b_valid_hold", bus.b_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    check("mrst b_valid", bus.b_valid, 1'b0);
    check("mrst r_valid", bus.r_valid, 1'b0);
    check("mrst wr_pulse", wr_pulse, 16'h0000);
    check_regs("mrst");
    rst = 1'b0;
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post b_valid c%0d", i), bus.b_valid, 1'b0);
      check($sformatf("post r_valid c%0d", i), bus.r_valid, 1'b0);
      check($sformatf("post ar_ready c%0d", i), bus.ar_ready, 1'b1);
    end
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    axi_write(32'h8, 32'h0BAD_F00D, 4'hF, OKAY, 16'h0004, "post wr");
    model[2] = 32'h0BAD_F00D;
    check_regs("post");
    axi_read(32'h8, 32'h0BAD_F00D, OKAY, "post rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of registers; power of two, 1..256.
REQ-002 SHALL have parameter RESET_VALUE, default '0, value every register takes on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port master, axi_lite_channel.slave modport, interface widths, the AXI-Lite target port; DW = data width in bits (32 or 64), B = DW/8.
REQ-006 SHALL have port reg_q, output, NUM_REGS*DW, current register contents; register i occupies bits [i*DW +: DW].
REQ-007 SHALL have port wr_pulse, output, NUM_REGS, one-cycle strobe per register written.

Function
REQ-008 SHALL decode addresses with index = addr[log2(B) +: log2(NUM_REGS)]; the address is in range iff addr < NUM_REGS*B; low log2(B) bits ignored.
REQ-009 SHALL ignore aw_prot and ar_prot.
REQ-010 Write path SHALL have two states: W_IDLE and W_RESP.
REQ-011 In W_IDLE, aw_ready and w_ready SHALL both equal (aw_valid && w_valid), so AW and W always handshake in the same cycle; both SHALL be 0 in W_RESP.
REQ-012 On AW+W handshake to an in-range address, SHALL update each byte k of register index where w_strb[k]=1, leave other bytes unchanged, and go to W_RESP.
REQ-013 The register update SHALL appear on reg_q, and wr_pulse[index]=1, in the cycle after the handshake, i.e. the same cycle b_valid first rises.
REQ-014 wr_pulse[index] SHALL be 1 even when w_strb=0 for an in-range address; the register value is unchanged in that case.
REQ-015 On AW+W handshake to an out-of-range address, SHALL write nothing, leave wr_pulse at 0, and go to W_RESP with DECERR.
REQ-016 In W_RESP, b_valid SHALL be 1 and b_resp SHALL be 2'b00 (OKAY) or 2'b11 (DECERR); b_valid and b_resp SHALL be held stable until b_ready.
REQ-017 On the b_valid && b_ready cycle, SHALL return to W_IDLE; the next write can handshake one cycle later.
REQ-018 There SHALL be at most one outstanding write.
REQ-019 Read path SHALL have two states: R_IDLE and R_RESP.
REQ-020 In R_IDLE, ar_ready SHALL be 1; in R_RESP it SHALL be 0.
REQ-021 On AR handshake, SHALL register r_data = register[index] and r_resp = OKAY for an in-range address, or r_data = 0 and r_resp = DECERR for an out-of-range address, and go to R_RESP; r_valid SHALL rise the next cycle.
REQ-022 r_data, r_resp and r_valid SHALL be held stable until r_ready; on the r_valid && r_ready cycle, SHALL return to R_IDLE.
REQ-023 Read and write paths SHALL be fully independent; each path's maximum throughput is one transaction per 2 cycles with zero-wait ready.
REQ-024 If an AR handshake and a write update target the same register in the same cycle, the read SHALL return the pre-write value.
REQ-025 AW-only or W-only valid SHALL NOT be accepted; SHALL wait indefinitely for the partner channel with no side effects.

Reset
REQ-026 While rst=1: all registers SHALL be RESET_VALUE; b_valid, r_valid and wr_pulse SHALL be 0; aw_ready, w_ready and ar_ready SHALL be 0; both FSMs SHALL be forced to IDLE.
REQ-027 Reset asserted mid-transaction SHALL abandon the pending B or R response without emitting it; the first cycle after rst falls SHALL be a clean W_IDLE/R_IDLE state.
REQ-028 Reset SHALL be sampled only on rising clk; the block SHALL have no asynchronous paths.

Verification
REQ-029 Basic write/read (DW=32): write addr 0x8, data 0xDEADBEEF, strb 0xF -> b_resp OKAY 1 cycle later, reg_q[2] = 0xDEADBEEF, wr_pulse = 0x0004 for 1 cycle; read 0x8 -> r_data 0xDEADBEEF, OKAY.
REQ-030 Partial strobe: register 1 = 0x11223344, write 0xAABBCCDD with strb 0x5 -> reg_q[1] = 0x11BB33DD.
REQ-031 Out of range (NUM_REGS=16, DW=32): write 0x40 -> b_resp DECERR, all reg_q unchanged, wr_pulse 0; read 0x44 -> r_data 0, r_resp DECERR.
REQ-032 Backpressure and skew: aw_valid 3 cycles before w_valid -> no handshake until both are high; then hold b_ready=0 for 5 cycles -> b_valid/b_resp stable, aw_ready=0 throughout.
REQ-033 Same-cycle conflict: AR to 0x4 in the same cycle as the write update of 0x4 (old 0x0, new 0x5) -> read returns 0x0, a later read returns 0x5.
REQ-034 Mid-transaction reset: write handshake, then rst=1 while b_valid=1 with b_ready=0 -> b_valid=0 next cycle, every reg_q = RESET_VALUE, no B emitted after rst falls.
